// File: rtl/ins_fetch_ctrl.sv
// Instruction fetch sequencer: PC -> instruction memory read -> IR write strobe.
// Optional memory-timeout detection is compiled in with `define FETCH_TIMEOUT_EN.
module ins_fetch_ctrl #(
    parameter int          TIMEOUT_CYC = 16,
    parameter logic [31:0] NOP_INS     = 32'h00000000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        FetchStart,
    input  logic [31:0] PC,
    output logic [31:0] MemAddr,
    output logic        MemRd,
    input  logic        MemRdy,
    input  logic [31:0] MemData,
    output logic [31:0] InsToIR,
    output logic        IRWre,
    output logic        FetchDone,
    output logic        FetchErr,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t      state, nxt;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ins_q, ins_d;
    logic        rd_q, rd_d;
    logic        irwre_q, err_q, busy_q;
    logic        start_ok, start_bad;

    assign start_ok  = FetchStart && (PC[1:0] == 2'b00);
    assign start_bad = FetchStart && (PC[1:0] != 2'b00);

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        nxt    = state;
        addr_d = addr_q;
        ins_d  = ins_q;
        rd_d   = rd_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d  = cnt_q;
`endif
        case (state)
            IDLE, ERR: begin
                if (start_ok) begin
                    nxt    = REQ;
                    addr_d = PC;
                    rd_d   = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d  = '0;
`endif
                end else if (start_bad) begin
                    nxt   = ERR;
                    rd_d  = 1'b0;
                    ins_d = NOP_INS;
                end
            end
            REQ: begin
                rd_d = 1'b1;
                if (MemRdy) begin
                    nxt   = DONE;
                    ins_d = MemData;
                    rd_d  = 1'b0;
                end
`ifdef FETCH_TIMEOUT_EN
                // A ready on the final allowed cycle still completes the fetch.
                else if (cnt_q == CNT_LAST) begin
                    nxt   = ERR;
                    rd_d  = 1'b0;
                    ins_d = NOP_INS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                nxt = IDLE;
            end
            default: begin
                nxt  = IDLE;
                rd_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            ins_q   <= NOP_INS;
            rd_q    <= 1'b0;
            irwre_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= nxt;
            addr_q  <= addr_d;
            ins_q   <= ins_d;
            rd_q    <= rd_d;
            irwre_q <= (nxt == DONE);
            err_q   <= (nxt == ERR);
            busy_q  <= (nxt == REQ) || (nxt == DONE);
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign MemAddr   = addr_q;
    assign MemRd     = rd_q;
    assign InsToIR   = ins_q;
    assign IRWre     = irwre_q;
    assign FetchDone = irwre_q;
    assign FetchErr  = err_q;
    assign Busy      = busy_q;

endmodule
